pe_mac_array: RTL and testbench
===============================

PE_MAC_ARRAY -- requirements
Module: pe_mac_array

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, rising edge; reset  in  1  asynchronous, active-high.
REQ-002 SHALL have: wen_i  in  1  config write strobe; total_id_i  in  8  input channels per accumulation.
REQ-003 SHALL have: pe_start_i  in  1  begin new accumulation; pe_busy_o  out  1  high when not IDLE.
REQ-004 SHALL have: weight_tile_1_i, weight_tile_2_i  in  signed 16 [5:0][5:0]  transformed weight tiles, out-depths 1/2; weight_valid_i  in  1; weight_ack_o  out  1.
REQ-005 SHALL have: input_tile_i  in  signed 16 [5:0][5:0]  transformed input tile; input_valid_i  in  1; input_ack_o  out  1.
REQ-006 SHALL have: acc_tile_1_o, acc_tile_2_o  out  signed 32 [5:0][5:0]; result_valid_o  out  1; result_ready_i  in  1.

Function
REQ-007 SHALL latch total_id_i into total_id_reg on wen_i only in IDLE; wen_i in other states ignored.
REQ-008 SHALL implement FSM IDLE, ACCUM, DONE.
REQ-009 IDLE: on pe_start_i clear all 72 accumulators and channel counter; go ACCUM, or DONE directly if total_id_reg==0.
REQ-010 pe_start_i outside IDLE SHALL be ignored.
REQ-011 ACCUM: fire = weight_valid_i & input_valid_i; weight_ack_o = input_ack_o = fire, combinational, same cycle; both acks 0 outside ACCUM.
REQ-012 On fire, element [i][j]: acc1 += weight_tile_1_i[i][j]*input_tile_i[i][j]; acc2 likewise with weight_tile_2_i; full 32-bit signed product.
REQ-013 Accumulation SHALL wrap two's-complement at 32 bits; no saturation.
REQ-014 Counter (8-bit) SHALL increment per fire; fire with counter==total_id_reg-1 SHALL transition to DONE next cycle.
REQ-015 Only one valid asserted SHALL not fire, not ack, not change state.
REQ-016 DONE: result_valid_o=1, acc tiles held stable; result_ready_i high -> IDLE next cycle; result_ready_i low -> hold indefinitely.
REQ-017 Result latency: result_valid_o SHALL rise the cycle after the final fire.
REQ-018 acc_tile outputs SHALL be driven from accumulator registers at all times; contents valid only while result_valid_o=1.
REQ-019 pe_busy_o SHALL be 1 in ACCUM and DONE.

Reset
REQ-020 On reset: state IDLE, counter 0, total_id_reg 0, all accumulators 0, result_valid_o 0, acks 0, pe_busy_o 0.
REQ-021 Reset mid-ACCUM or mid-DONE SHALL abort immediately; partial sums discarded, no result_valid_o pulse.

Structure
REQ-022 Shared package SHALL hold: state enum pe_state_t (2-bit), TILE_N=6, DATA_W=16, ACC_W=32.
REQ-023 Per-element multiply-accumulate SHALL be sub-module pe_mac_cell (clear, enable, one data input, two weights, two accumulators), instantiated 36 times.

Verification
REQ-024 total_id=3, all weights 2, inputs 5, both valids held high -> acks high 3 cycles, result_valid_o on 4th cycle after ACCUM entry, every acc element = 30.
REQ-025 total_id=2, weight_valid_i toggled, input_valid_i high -> fires only when both high; final acc equals sum of exactly 2 products; no extra ack.
REQ-026 total_id=1, weight -32768, input -32768, then repeat run with total_id=2 -> acc 0x40000000, then 0x80000000 (wrap, negative).
REQ-027 total_id=0, pe_start_i -> DONE next cycle, all acc 0; result_ready_i held low 5 cycles -> result_valid_o stays 1, outputs stable; ready high -> IDLE.
REQ-028 Reset asserted after 1 of 4 fires -> outputs at reset values; new run total_id=1, weight 3, input 4 -> acc 12, no carry-over.
REQ-029 wen_i with total_id_i=9 during ACCUM -> ignored; current run completes with old count; next run uses 9 only if rewritten in IDLE.

Source files
------------

// File: rtl/pe_mac_array_pkg.sv
// ============================================================================
// Module   : pe_mac_array_pkg
// Purpose  : Shared types and sizes for the Winograd-domain PE MAC array.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pe_mac_array_pkg;

  localparam int TILE_N = 6;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } pe_state_t;

endpackage

`default_nettype wire

// File: rtl/pe_mac_array_mac_cell.sv
// ============================================================================
// Module   : pe_mac_cell
// Purpose  : One tile element: a shared input times two weights, summed into
//            two wrapping 32-bit accumulators.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_mac_cell
  import pe_mac_array_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] data_i,
  input  logic signed [DATA_W-1:0] weight_1_i,
  input  logic signed [DATA_W-1:0] weight_2_i,
  output logic signed [ACC_W-1:0]  acc_1_o,
  output logic signed [ACC_W-1:0]  acc_2_o
);

  logic signed [ACC_W-1:0] w_data_ext;
  logic signed [ACC_W-1:0] w_weight_1_ext;
  logic signed [ACC_W-1:0] w_weight_2_ext;
  logic signed [ACC_W-1:0] w_prod_1;
  logic signed [ACC_W-1:0] w_prod_2;
  logic signed [ACC_W-1:0] r_acc_1;
  logic signed [ACC_W-1:0] r_acc_2;

  // Widen before multiplying so the full 16x16 product survives.
  assign w_data_ext     = {{(ACC_W-DATA_W){data_i[DATA_W-1]}}, data_i};
  assign w_weight_1_ext = {{(ACC_W-DATA_W){weight_1_i[DATA_W-1]}}, weight_1_i};
  assign w_weight_2_ext = {{(ACC_W-DATA_W){weight_2_i[DATA_W-1]}}, weight_2_i};
  assign w_prod_1       = w_weight_1_ext * w_data_ext;
  assign w_prod_2       = w_weight_2_ext * w_data_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc_1 <= '0;
      r_acc_2 <= '0;
    end else if (clear) begin
      r_acc_1 <= '0;
      r_acc_2 <= '0;
    end else if (enable) begin
      r_acc_1 <= r_acc_1 + w_prod_1;
      r_acc_2 <= r_acc_2 + w_prod_2;
    end
  end

  assign acc_1_o = r_acc_1;
  assign acc_2_o = r_acc_2;

endmodule

`default_nettype wire

// File: rtl/pe_mac_array.sv
// ============================================================================
// Module   : pe_mac_array
// Purpose  : 6x6 element-wise MAC over total_id input channels, two output
//            depths, with a valid/ready result handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_mac_array
  import pe_mac_array_pkg::*;
(
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         wen_i,
  input  logic [7:0]                                   total_id_i,
  input  logic                                         pe_start_i,
  output logic                                         pe_busy_o,
  input  logic signed [TILE_N-1:0][TILE_N-1:0][DATA_W-1:0] weight_tile_1_i,
  input  logic signed [TILE_N-1:0][TILE_N-1:0][DATA_W-1:0] weight_tile_2_i,
  input  logic                                         weight_valid_i,
  output logic                                         weight_ack_o,
  input  logic signed [TILE_N-1:0][TILE_N-1:0][DATA_W-1:0] input_tile_i,
  input  logic                                         input_valid_i,
  output logic                                         input_ack_o,
  output logic signed [TILE_N-1:0][TILE_N-1:0][ACC_W-1:0]  acc_tile_1_o,
  output logic signed [TILE_N-1:0][TILE_N-1:0][ACC_W-1:0]  acc_tile_2_o,
  output logic                                         result_valid_o,
  input  logic                                         result_ready_i
);

  pe_state_t  r_state;
  pe_state_t  w_state_next;
  logic [7:0] r_total_id;
  logic [7:0] r_count;
  logic       w_fire;
  logic       w_clear;
  logic       w_last;

  assign w_last = (r_count == (r_total_id - 8'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (pe_start_i) begin
          w_state_next = (r_total_id == 8'd0) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (w_fire && w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (result_ready_i) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    pe_busy_o      = 1'b0;
    result_valid_o = 1'b0;
    w_fire         = 1'b0;
    w_clear        = 1'b0;
    unique case (r_state)
      ST_IDLE:  w_clear = pe_start_i;
      ST_ACCUM: begin
        pe_busy_o = 1'b1;
        w_fire    = weight_valid_i & input_valid_i;
      end
      ST_DONE: begin
        pe_busy_o      = 1'b1;
        result_valid_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign weight_ack_o = w_fire;
  assign input_ack_o  = w_fire;

  // Channel count is only reprogrammable between runs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_total_id <= 8'd0;
    end else if (wen_i && (r_state == ST_IDLE)) begin
      r_total_id <= total_id_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 8'd0;
    end else if (w_clear) begin
      r_count <= 8'd0;
    end else if (w_fire) begin
      r_count <= r_count + 8'd1;
    end
  end

  for (genvar gi = 0; gi < TILE_N; gi++) begin : g_row
    for (genvar gj = 0; gj < TILE_N; gj++) begin : g_col
      pe_mac_cell u_cell (
        .clk        (clk),
        .reset      (reset),
        .clear      (w_clear),
        .enable     (w_fire),
        .data_i     (input_tile_i[gi][gj]),
        .weight_1_i (weight_tile_1_i[gi][gj]),
        .weight_2_i (weight_tile_2_i[gi][gj]),
        .acc_1_o    (acc_tile_1_o[gi][gj]),
        .acc_2_o    (acc_tile_2_o[gi][gj])
      );
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pe_mac_array.sv
// ============================================================================
// Module   : tb_pe_mac_array
// Purpose  : Self-checking bench for pe_mac_array against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pe_mac_array;
  import pe_mac_array_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic wen_i;
  logic [7:0] total_id_i;
  logic pe_start_i;
  logic pe_busy_o;
  logic signed [TILE_N-1:0][TILE_N-1:0][DATA_W-1:0] wt1, wt2, inp;
  logic weight_valid_i, input_valid_i;
  logic weight_ack_o, input_ack_o;
  logic signed [TILE_N-1:0][TILE_N-1:0][ACC_W-1:0] acc1, acc2;
  logic result_valid_o;
  logic result_ready_i;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: run phase 0=idle, 1=collecting channels, 2=result held.
  int         m_phase;
  logic [7:0] m_total;
  int         m_count;
  int         m_acc1 [TILE_N][TILE_N];
  int         m_acc2 [TILE_N][TILE_N];

  always #5 clk = ~clk;

  pe_mac_array dut (
    .clk             (clk),
    .reset           (reset),
    .wen_i           (wen_i),
    .total_id_i      (total_id_i),
    .pe_start_i      (pe_start_i),
    .pe_busy_o       (pe_busy_o),
    .weight_tile_1_i (wt1),
    .weight_tile_2_i (wt2),
    .weight_valid_i  (weight_valid_i),
    .weight_ack_o    (weight_ack_o),
    .input_tile_i    (inp),
    .input_valid_i   (input_valid_i),
    .input_ack_o     (input_ack_o),
    .acc_tile_1_o    (acc1),
    .acc_tile_2_o    (acc2),
    .result_valid_o  (result_valid_o),
    .result_ready_i  (result_ready_i)
  );

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase <= 0;
      m_total <= 8'd0;
      m_count <= 0;
      for (int i = 0; i < TILE_N; i++)
        for (int j = 0; j < TILE_N; j++) begin
          m_acc1[i][j] <= 0;
          m_acc2[i][j] <= 0;
        end
    end else begin
      case (m_phase)
        0: begin
          if (wen_i) m_total <= total_id_i;
          if (pe_start_i) begin
            for (int i = 0; i < TILE_N; i++)
              for (int j = 0; j < TILE_N; j++) begin
                m_acc1[i][j] <= 0;
                m_acc2[i][j] <= 0;
              end
            m_count <= 0;
            m_phase <= (m_total == 8'd0) ? 2 : 1;
          end
        end
        1: begin
          if (weight_valid_i && input_valid_i) begin
            for (int i = 0; i < TILE_N; i++)
              for (int j = 0; j < TILE_N; j++) begin
                m_acc1[i][j] <= m_acc1[i][j] +
                  int'(shortint'(wt1[i][j])) * int'(shortint'(inp[i][j]));
                m_acc2[i][j] <= m_acc2[i][j] +
                  int'(shortint'(wt2[i][j])) * int'(shortint'(inp[i][j]));
              end
            m_count <= m_count + 1;
            if (m_count + 1 == int'(m_total)) m_phase <= 2;
          end
        end
        default: if (result_ready_i) m_phase <= 0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      int fi1, fj1, fi2, fj2;
      bit fire;
      fi1 = 0; fj1 = 0; fi2 = 0; fj2 = 0;
      fire = (m_phase == 1) && weight_valid_i && input_valid_i;
      chk("cmp_weight_ack", 32'(weight_ack_o), 32'(fire));
      chk("cmp_input_ack", 32'(input_ack_o), 32'(fire));
      chk("cmp_busy", 32'(pe_busy_o), 32'(m_phase != 0));
      chk("cmp_result_valid", 32'(result_valid_o), 32'(m_phase == 2));
      for (int i = TILE_N - 1; i >= 0; i--)
        for (int j = TILE_N - 1; j >= 0; j--) begin
          if (acc1[i][j] !== 32'(m_acc1[i][j])) begin fi1 = i; fj1 = j; end
          if (acc2[i][j] !== 32'(m_acc2[i][j])) begin fi2 = i; fj2 = j; end
        end
      chk("cmp_acc1", acc1[fi1][fj1], 32'(m_acc1[fi1][fj1]));
      chk("cmp_acc2", acc2[fi2][fj2], 32'(m_acc2[fi2][fj2]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_total(input logic [7:0] n);
    wen_i = 1'b1;
    total_id_i = n;
    step();
    wen_i = 1'b0;
  endtask

  task automatic pulse_start();
    pe_start_i = 1'b1;
    step();
    pe_start_i = 1'b0;
  endtask

  task automatic set_uniform(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    for (int i = 0; i < TILE_N; i++)
      for (int j = 0; j < TILE_N; j++) begin
        wt1[i][j] = a;
        wt2[i][j] = b;
        inp[i][j] = c;
      end
  endtask

  task automatic set_random();
    for (int i = 0; i < TILE_N; i++)
      for (int j = 0; j < TILE_N; j++) begin
        wt1[i][j] = 16'($urandom);
        wt2[i][j] = 16'($urandom);
        inp[i][j] = 16'($urandom);
      end
  endtask

  // mode 0: inputs untouched; 1: toggle weight_valid with fresh data;
  // 2: random valids, data and ignored wen/start noise.
  task automatic run(input int mode, input int budget, output int fires, output int rv_cyc);
    fires = 0;
    rv_cyc = -1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (mode == 1) begin
        weight_valid_i = ~weight_valid_i;
        set_random();
      end else if (mode == 2) begin
        weight_valid_i = ($urandom_range(0, 3) != 0);
        input_valid_i  = ($urandom_range(0, 3) != 0);
        wen_i          = ($urandom_range(0, 7) == 0);
        total_id_i     = 8'($urandom);
        pe_start_i     = ($urandom_range(0, 7) == 0);
        set_random();
      end
      #1;
      if (result_valid_o) begin
        rv_cyc = cyc;
        break;
      end
      if (weight_ack_o) fires++;
      step();
    end
    wen_i = 1'b0;
    pe_start_i = 1'b0;
    if (rv_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: got no result_valid, expected one within %0d cycles", budget);
    end
  endtask

  task automatic finish_result(input int delay);
    result_ready_i = 1'b0;
    repeat (delay) step();
    result_ready_i = 1'b1;
    step();
    result_ready_i = 1'b0;
  endtask

  initial begin
    int fires, rv_cyc;
    logic [31:0] snap;
    reset = 1'b1;
    wen_i = 1'b0;
    total_id_i = 8'd0;
    pe_start_i = 1'b0;
    weight_valid_i = 1'b0;
    input_valid_i = 1'b0;
    result_ready_i = 1'b0;
    set_uniform(16'd0, 16'd0, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    cmp_en = 1'b1;

    chk("reset_busy", 32'(pe_busy_o), 32'd0);
    chk("reset_result_valid", 32'(result_valid_o), 32'd0);
    chk("reset_acc1", acc1[3][2], 32'd0);

    // 3 channels of 2*5 -> 30, acks on 3 cycles, valid on the 4th.
    write_total(8'd3);
    set_uniform(16'd2, 16'd2, 16'd5);
    weight_valid_i = 1'b1;
    input_valid_i = 1'b1;
    pulse_start();
    run(0, 20, fires, rv_cyc);
    chk("t024_fires", 32'(fires), 32'd3);
    chk("t024_latency", 32'(rv_cyc), 32'd3);
    chk("t024_acc1_00", acc1[0][0], 32'd30);
    chk("t024_acc2_55", acc2[5][5], 32'd30);
    finish_result(0);
    weight_valid_i = 1'b0;
    input_valid_i = 1'b0;

    // weight_valid toggling: exactly two products accumulate.
    write_total(8'd2);
    input_valid_i = 1'b1;
    pulse_start();
    run(1, 30, fires, rv_cyc);
    chk("t025_fires", 32'(fires), 32'd2);
    finish_result(1);
    weight_valid_i = 1'b0;
    input_valid_i = 1'b0;

    // Extreme operands: 2^30 once, then twice wraps to 0x80000000.
    write_total(8'd1);
    set_uniform(16'h8000, 16'h8000, 16'h8000);
    weight_valid_i = 1'b1;
    input_valid_i = 1'b1;
    pulse_start();
    run(0, 20, fires, rv_cyc);
    chk("t026_acc1_single", acc1[0][0], 32'h4000_0000);
    chk("t026_acc2_single", acc2[4][1], 32'h4000_0000);
    finish_result(0);
    write_total(8'd2);
    pulse_start();
    run(0, 20, fires, rv_cyc);
    chk("t026_acc1_wrap", acc1[2][3], 32'h8000_0000);
    chk("t026_acc2_wrap", acc2[5][0], 32'h8000_0000);
    finish_result(0);
    weight_valid_i = 1'b0;
    input_valid_i = 1'b0;

    // Zero channels: straight to result, held while ready is low.
    write_total(8'd0);
    pulse_start();
    run(0, 5, fires, rv_cyc);
    chk("t027_latency", 32'(rv_cyc), 32'd0);
    chk("t027_acc1", acc1[1][1], 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t027_hold_valid", 32'(result_valid_o), 32'd1);
      chk("t027_hold_acc", acc2[1][4], 32'd0);
    end
    finish_result(0);
    chk("t027_idle_busy", 32'(pe_busy_o), 32'd0);

    // Reset after one of four fires aborts, then a clean 3*4 run.
    write_total(8'd4);
    set_uniform(16'd3, 16'd3, 16'd7);
    weight_valid_i = 1'b1;
    input_valid_i = 1'b1;
    pulse_start();
    step();
    chk("t028_partial", acc1[0][0], 32'd21);
    reset = 1'b1;
    #1;
    chk("t028_reset_busy", 32'(pe_busy_o), 32'd0);
    chk("t028_reset_valid", 32'(result_valid_o), 32'd0);
    chk("t028_reset_ack", 32'(weight_ack_o), 32'd0);
    chk("t028_reset_acc", acc1[0][0], 32'd0);
    step();
    reset = 1'b0;
    write_total(8'd1);
    set_uniform(16'd3, 16'd3, 16'd4);
    pulse_start();
    run(0, 20, fires, rv_cyc);
    chk("t028_acc1", acc1[3][3], 32'd12);
    finish_result(0);

    // wen during ACCUM is ignored until rewritten in IDLE.
    write_total(8'd2);
    set_random();
    pulse_start();
    wen_i = 1'b1;
    total_id_i = 8'd9;
    run(0, 30, fires, rv_cyc);
    chk("t029_fires_old", 32'(fires), 32'd2);
    finish_result(0);
    pulse_start();
    run(0, 30, fires, rv_cyc);
    chk("t029_fires_kept", 32'(fires), 32'd2);
    finish_result(0);
    write_total(8'd9);
    pulse_start();
    run(0, 30, fires, rv_cyc);
    chk("t029_fires_new", 32'(fires), 32'd9);
    snap = acc1[4][4];
    finish_result(2);
    chk("t029_acc_after_done", acc1[4][4], snap);

    // Randomised runs checked by the model every cycle.
    for (int r = 0; r < 12; r++) begin
      write_total(8'($urandom_range(1, 6)));
      pulse_start();
      run(2, 200, fires, rv_cyc);
      finish_result($urandom_range(0, 3));
    end
    weight_valid_i = 1'b0;
    input_valid_i = 1'b0;
    step();

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
